if_fetch: RTL and testbench

Instruction-fetch stage that drives the write side of the IF/ID pipeline register. It owns the program counter and issues requests to instruction memory over a req/ack handshake. Each cycle it presents a (pc, instruction) pair plus a flush to IF/ID. It also absorbs branch redirects from the execute stage and stall requests from the hazard unit. IF/ID has no enable input, so this block makes IF/ID hold its contents by re-presenting the last delivered pair.

---
 rtl/if_fetch.sv | 87 ++++++++
 tb/tb_if_fetch.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage driving the IF/ID write side over an imem req/ack handshake.
// Define IF_SKID_BUFFER_EN to add a one-entry skid buffer so a fetch can complete during stall.
module if_fetch #(
  parameter int len = 32,
  parameter logic [len-1:0] RESET_PC = '0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           stall,
  input  logic           branch_taken,
  input  logic [len-1:0] branch_target,
  output logic           imem_req,
  output logic [len-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [len-1:0] imem_rdata,
  output logic [len-1:0] pc_out,
  output logic [len-1:0] instruction_out,
  output logic           flush_out
);
  typedef enum logic {FETCH, DRAIN} state_t;
  state_t state;
  logic [len-1:0] pc, drain_addr, last_pc, last_inst, pc_next4;
  logic [len-1:0] pend_pc, pend_inst;
  logic pend_valid, in_fetch, ack_now, hold, deliver_pend, deliver_fetch, capture;
  assign pc_next4 = pc + len'(4);
  assign in_fetch = state == FETCH && !reset;
  assign ack_now = imem_req && imem_ack;
  assign imem_addr = state == DRAIN ? drain_addr : pc;
  assign hold = in_fetch && !branch_taken && stall;
  assign deliver_pend = in_fetch && !branch_taken && !stall && pend_valid;
  assign deliver_fetch = in_fetch && !branch_taken && !stall && !pend_valid && ack_now;
`ifdef IF_SKID_BUFFER_EN
  assign capture = hold && ack_now;
  assign imem_req = !reset && (state == DRAIN || !pend_valid);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pend_valid <= 1'b0;
      pend_pc <= '0;
      pend_inst <= '0;
    end else if (state == FETCH && branch_taken) begin
      pend_valid <= 1'b0;
    end else if (capture) begin
      pend_valid <= 1'b1;
      pend_pc <= pc_next4;
      pend_inst <= imem_rdata;
    end else if (deliver_pend) begin
      pend_valid <= 1'b0;
    end
`else
  logic outstanding;
  assign capture = 1'b0;
  assign pend_valid = 1'b0;
  assign pend_pc = '0;
  assign pend_inst = '0;
  // an ack seen during stall is left unconsumed, so the request stays outstanding
  assign imem_req = !reset && (state == DRAIN || !stall || outstanding);
  always_ff @(posedge clock or posedge reset)
    if (reset) outstanding <= 1'b0;
    else outstanding <= state == FETCH && !branch_taken && imem_req && !(imem_ack && !stall);
`endif
  always_comb begin
    flush_out = !(hold || deliver_pend || deliver_fetch);
    pc_out = flush_out ? '0 : hold ? last_pc : deliver_pend ? pend_pc : pc_next4;
    instruction_out = flush_out ? '0 : hold ? last_inst : deliver_pend ? pend_inst : imem_rdata;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      drain_addr <= '0;
      last_pc <= '0;
      last_inst <= '0;
    end else begin
      if (branch_taken) pc <= branch_target;
      else if (capture || deliver_fetch) pc <= pc_next4;
      if (deliver_pend || deliver_fetch) begin
        last_pc <= pc_out;
        last_inst <= instruction_out;
      end
      if (state == FETCH && branch_taken && imem_req && !imem_ack) begin
        state <= DRAIN;
        drain_addr <= pc;
      end else if (state == DRAIN && imem_ack) begin
        state <= FETCH;
      end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed stimulus with scoreboard queues for requests and IF/ID deliveries.
module tb_if_fetch;
  localparam logic [31:0] K = 32'hA5A5A5A5;
  logic clock = 0, reset = 1, stall = 0, branch_taken = 0, imem_ack = 0;
  logic [31:0] branch_target = 0, imem_rdata, imem_addr, pc_out, instruction_out;
  logic imem_req, flush_out;
  logic w_req, w_flush;
  logic [31:0] w_addr, w_rdata, w_pc, w_inst;
  int checks = 0, fails = 0, cyc = -1;
  bit run = 0;
  typedef struct packed {logic req; logic [31:0] addr;} req_t;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} del_t;
  req_t req_q[$];
  del_t del_q[$];

  always #5 clock = ~clock;
  assign imem_rdata = imem_addr ^ K;
  assign w_rdata = w_addr ^ K;

  if_fetch #(.len(32), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .instruction_out(instruction_out), .flush_out(flush_out)
  );

  if_fetch #(.len(32), .RESET_PC(32'hFFFFFFFC)) u_wrap (
    .clock(clock), .reset(reset), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata(w_rdata), .pc_out(w_pc),
    .instruction_out(w_inst), .flush_out(w_flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic row(input logic a, input logic s, input logic b, input logic [31:0] t,
                     input logic er, input logic [31:0] ea, input logic ef,
                     input logic [31:0] ep, input logic [31:0] ia);
    imem_ack = a;
    stall = s;
    branch_taken = b;
    branch_target = t;
    req_q.push_back(req_t'{er, ea});
    if (!ef) del_q.push_back(del_t'{ep, ia ^ K});
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) if (run) begin
    req_t r;
    del_t d;
    cyc++;
    if (req_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL req_q underflow at cycle %0d", cyc);
    end else begin
      r = req_q.pop_front();
      chk($sformatf("imem_req c%0d", cyc), {31'b0, imem_req}, {31'b0, r.req});
      if (r.req) chk($sformatf("imem_addr c%0d", cyc), imem_addr, r.addr);
    end
    if (!flush_out) begin
      if (del_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected delivery c%0d: got pc %h, required a bubble", cyc, pc_out);
      end else begin
        d = del_q.pop_front();
        chk($sformatf("pc_out c%0d", cyc), pc_out, d.pc);
        chk($sformatf("instruction_out c%0d", cyc), instruction_out, d.inst);
      end
    end
    if (cyc == 0) begin
      chk("wrap imem_addr0", w_addr, 32'hFFFFFFFC);
      chk("wrap flush0", {31'b0, w_flush}, 32'h0);
      chk("wrap pc_out0", w_pc, 32'h0);
      chk("wrap inst0", w_inst, 32'hFFFFFFFC ^ K);
    end
    if (cyc == 1) begin
      chk("wrap imem_addr1", w_addr, 32'h0);
      chk("wrap pc_out1", w_pc, 32'h4);
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset imem_req", {31'b0, imem_req}, 32'h0);
    chk("reset flush_out", {31'b0, flush_out}, 32'h1);
    chk("reset pc_out", pc_out, 32'h0);
    chk("reset instruction_out", instruction_out, 32'h0);
    chk("reset wrap imem_req", {31'b0, w_req}, 32'h0);
    reset = 0;
    run = 1;
    row(1, 0, 0, 0,     1, 'h000, 0, 'h004, 'h000);
    row(1, 0, 0, 0,     1, 'h004, 0, 'h008, 'h004);
    row(1, 0, 0, 0,     1, 'h008, 0, 'h00C, 'h008);
    row(1, 0, 0, 0,     1, 'h00C, 0, 'h010, 'h00C);
    row(0, 0, 0, 0,     1, 'h010, 1, 0, 0);
    row(0, 0, 0, 0,     1, 'h010, 1, 0, 0);
    row(1, 0, 0, 0,     1, 'h010, 0, 'h014, 'h010);
    row(1, 0, 1, 'h100, 1, 'h014, 1, 0, 0);
    row(1, 0, 0, 0,     1, 'h100, 0, 'h104, 'h100);
    row(1, 0, 0, 0,     1, 'h104, 0, 'h108, 'h104);
    row(0, 0, 1, 'h200, 1, 'h108, 1, 0, 0);
    row(0, 0, 0, 0,     1, 'h108, 1, 0, 0);
    row(1, 0, 0, 0,     1, 'h108, 1, 0, 0);
    row(1, 0, 0, 0,     1, 'h200, 0, 'h204, 'h200);
    row(1, 0, 0, 0,     1, 'h204, 0, 'h208, 'h204);
    row(0, 0, 1, 'h300, 1, 'h208, 1, 0, 0);
    row(0, 0, 1, 'h400, 1, 'h208, 1, 0, 0);
    row(1, 0, 0, 0,     1, 'h208, 1, 0, 0);
    row(1, 0, 0, 0,     1, 'h400, 0, 'h404, 'h400);
`ifdef IF_SKID_BUFFER_EN
    row(1, 1, 0, 0,     1, 'h404, 0, 'h404, 'h400);
    row(0, 1, 0, 0,     0, 0,     0, 'h404, 'h400);
    row(0, 0, 0, 0,     0, 0,     0, 'h408, 'h404);
    row(0, 0, 0, 0,     1, 'h408, 1, 0, 0);
    row(1, 1, 0, 0,     1, 'h408, 0, 'h408, 'h404);
    row(0, 0, 0, 0,     0, 0,     0, 'h40C, 'h408);
    row(0, 1, 1, 'h500, 1, 'h40C, 1, 0, 0);
    row(1, 0, 0, 0,     1, 'h40C, 1, 0, 0);
    row(1, 0, 0, 0,     1, 'h500, 0, 'h504, 'h500);
`else
    row(0, 1, 0, 0,     0, 0,     0, 'h404, 'h400);
    row(0, 1, 0, 0,     0, 0,     0, 'h404, 'h400);
    row(1, 0, 0, 0,     1, 'h404, 0, 'h408, 'h404);
    row(0, 0, 0, 0,     1, 'h408, 1, 0, 0);
    row(1, 1, 0, 0,     1, 'h408, 0, 'h408, 'h404);
    row(1, 0, 0, 0,     1, 'h408, 0, 'h40C, 'h408);
    row(0, 1, 1, 'h500, 0, 0,     1, 0, 0);
    row(1, 0, 0, 0,     1, 'h500, 0, 'h504, 'h500);
    row(1, 0, 0, 0,     1, 'h504, 0, 'h508, 'h504);
`endif
    run = 0;
    imem_ack = 0;
    stall = 0;
    branch_taken = 0;
    #1;
    chk("pre-abort imem_req", {31'b0, imem_req}, 32'h1);
    reset = 1;
    #1;
    chk("abort imem_req", {31'b0, imem_req}, 32'h0);
    chk("abort flush_out", {31'b0, flush_out}, 32'h1);
    chk("abort pc_out", pc_out, 32'h0);
    chk("req_q drained", req_q.size(), 32'h0);
    chk("del_q drained", del_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
